// File: rtl/spike_shift_detector_pkg.sv
// Shared types and helpers for the spike shift detector and the shifter's encoder side.
package spike_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  // Wide enough for any candidate index the detector is configured with.
  typedef logic [7:0] shift_idx_t;

  // Returns bit 'pos' of the one-hot encoding of 'idx'.
  function automatic logic onehot_from_idx(shift_idx_t idx, shift_idx_t pos);
    return idx == pos;
  endfunction

  function automatic int shift_from_idx(shift_idx_t idx, shift_idx_t max_mag);
    return int'(idx) - int'(max_mag);
  endfunction

endpackage

// File: rtl/spike_shift_detector_if.sv
// Request/result handshake bundle between a producer/consumer and the detector.
interface spike_shift_detector_if #(
  parameter int LEN           = 8,
  parameter int MAX_SHIFT_MAG = 2
) ();
  logic [0:LEN-1]             ref_ip;
  logic [0:LEN-1]             obs_ip;
  logic                       in_valid;
  logic                       in_ready;
  logic [0:2*MAX_SHIFT_MAG]   shift_mag;
  logic                       match;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output ref_ip, obs_ip, in_valid, out_ready,
    input  in_ready, shift_mag, match, out_valid
  );

  modport slave (
    input  ref_ip, obs_ip, in_valid, out_ready,
    output in_ready, shift_mag, match, out_valid
  );
endinterface

// File: rtl/spike_shift_detector_vec_shift.sv
// Combinational shift of a spike vector by a signed slot count (positive = delay).
module spike_vec_shift #(
  parameter int LEN         = 8,
  parameter bit WRAP_AROUND = 1'b0
) (
  input  logic [0:LEN-1]      vec_i,
  input  logic signed [31:0]  shift_i,
  output logic [0:LEN-1]      vec_o
);
  logic [31:0] mag;
  logic [31:0] rot;

  always_comb begin
    mag = shift_i[31] ? 32'(-shift_i) : 32'(shift_i);
    rot = mag % 32'(LEN);
    if (WRAP_AROUND) begin
      if (shift_i[31]) vec_o = (vec_i >> rot) | (vec_i << (32'(LEN) - rot));
      else             vec_o = (vec_i << rot) | (vec_i >> (32'(LEN) - rot));
    end else if (mag >= 32'(LEN)) begin
      vec_o = '0;
    end else if (shift_i[31]) begin
      vec_o = vec_i >> mag;
    end else begin
      vec_o = vec_i << mag;
    end
  end
endmodule

// File: rtl/spike_shift_detector.sv
// Searches candidate shifts one per cycle and reports the first that maps ref onto obs.
module spike_shift_detector
  import spike_pkg::*;
#(
  parameter int LEN           = 8,
  parameter int MAX_SHIFT_MAG = 2,
  parameter bit WRAP_AROUND   = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  spike_shift_detector_if.slave  bus
);
  localparam int NCAND = 2 * MAX_SHIFT_MAG + 1;
  localparam int IDX_W = $clog2(NCAND);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [0:LEN-1]     ref_q, ref_d;
  logic [0:LEN-1]     obs_q, obs_d;
  logic [0:NCAND-1]   shift_mag_q, shift_mag_d;
  logic               match_q, match_d;
  logic [0:LEN-1]     cand;
  logic signed [31:0] cand_shift;

  assign cand_shift = shift_from_idx(shift_idx_t'(idx_q), shift_idx_t'(MAX_SHIFT_MAG));

  // One shifter, time-multiplexed over all candidates.
  spike_vec_shift #(.LEN(LEN), .WRAP_AROUND(WRAP_AROUND)) u_shift (
    .vec_i   (ref_q),
    .shift_i (cand_shift),
    .vec_o   (cand)
  );

  assign bus.in_ready  = (state_q == IDLE) && !reset;
  assign bus.out_valid = (state_q == DONE);
  assign bus.shift_mag = shift_mag_q;
  assign bus.match     = match_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ref_d       = ref_q;
    obs_d       = obs_q;
    shift_mag_d = shift_mag_q;
    match_d     = match_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ref_d   = bus.ref_ip;
          obs_d   = bus.obs_ip;
          idx_d   = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (ref_q == '0) begin
          // Nothing to align: report zero shift, matching only an empty observation.
          for (int i = 0; i < NCAND; i++)
            shift_mag_d[i] = onehot_from_idx(shift_idx_t'(MAX_SHIFT_MAG), shift_idx_t'(i));
          match_d = (obs_q == '0);
          state_d = DONE;
        end else if (cand == obs_q) begin
          for (int i = 0; i < NCAND; i++)
            shift_mag_d[i] = onehot_from_idx(shift_idx_t'(idx_q), shift_idx_t'(i));
          match_d = 1'b1;
          state_d = DONE;
        end else if (idx_q == IDX_W'(NCAND - 1)) begin
          shift_mag_d = '0;
          match_d     = 1'b0;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shift_mag_q <= '0;
      match_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_mag_q <= shift_mag_d;
      match_q     <= match_d;
    end
  end

  always_ff @(posedge clock) begin
    ref_q <= ref_d;
    obs_q <= obs_d;
  end
endmodule

// File: tb/tb_spike_shift_detector.sv
// Directed bench: zero-fill and rotating detectors side by side, LEN=8, MAX_SHIFT_MAG=2.
module tb_spike_shift_detector;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  spike_shift_detector_if #(.LEN(8), .MAX_SHIFT_MAG(2)) b0 ();
  spike_shift_detector_if #(.LEN(8), .MAX_SHIFT_MAG(2)) b1 ();

  spike_shift_detector #(.LEN(8), .MAX_SHIFT_MAG(2), .WRAP_AROUND(1'b0)) dut0 (
    .clock (clock), .reset (reset), .bus (b0)
  );
  spike_shift_detector #(.LEN(8), .MAX_SHIFT_MAG(2), .WRAP_AROUND(1'b1)) dut1 (
    .clock (clock), .reset (reset), .bus (b1)
  );

  // Stimulus helper: waits for idle, submits one pair, counts edges until out_valid.
  task automatic run_search(input bit wrap, input logic [7:0] r, input logic [7:0] o,
                            output int edges, output logic [4:0] mag, output logic m);
    logic rdy;
    @(negedge clock);
    for (int k = 0; k < 12; k++) begin
      rdy = wrap ? b1.in_ready : b0.in_ready;
      if (rdy) break;
      @(negedge clock);
    end
    if (!wrap) begin b0.ref_ip = r; b0.obs_ip = o; b0.in_valid = 1'b1; end
    else       begin b1.ref_ip = r; b1.obs_ip = o; b1.in_valid = 1'b1; end
    @(posedge clock);
    #1;
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    edges = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if ((wrap ? b1.out_valid : b0.out_valid) === 1'b1) begin
        edges = k;
        break;
      end
    end
    mag = wrap ? b1.shift_mag : b0.shift_mag;
    m   = wrap ? b1.match : b0.match;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", b0.in_ready); end
    n_checks++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", b0.out_valid); end
    n_checks++; if (b0.match !== 1'b0) begin n_fail++; $display("FAIL reset_match got=%b exp=0", b0.match); end
    n_checks++; if (b0.shift_mag !== 5'b00000) begin n_fail++; $display("FAIL reset_shift_mag got=%b exp=00000", b0.shift_mag); end
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_checks++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", b0.in_ready); end
    n_checks++; if (b1.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready_wrap got=%b exp=1", b1.in_ready); end
  endtask

  task automatic test_delay_pos2();
    int e; logic [4:0] mg; logic m;
    run_search(1'b0, 8'b0000_0010, 8'b0000_1000, e, mg, m);
    n_checks++; if (e != 5) begin n_fail++; $display("FAIL delay2_latency got=%0d exp=5", e); end
    n_checks++; if (mg !== 5'b00001) begin n_fail++; $display("FAIL delay2_mag got=%b exp=00001", mg); end
    n_checks++; if (m !== 1'b1) begin n_fail++; $display("FAIL delay2_match got=%b exp=1", m); end
  endtask

  task automatic test_advance_neg1();
    int e; logic [4:0] mg; logic m;
    run_search(1'b0, 8'b0110_0000, 8'b0011_0000, e, mg, m);
    n_checks++; if (e != 2) begin n_fail++; $display("FAIL adv1_latency got=%0d exp=2", e); end
    n_checks++; if (mg !== 5'b01000) begin n_fail++; $display("FAIL adv1_mag got=%b exp=01000", mg); end
    n_checks++; if (m !== 1'b1) begin n_fail++; $display("FAIL adv1_match got=%b exp=1", m); end
  endtask

  task automatic test_no_match();
    int e; logic [4:0] mg; logic m;
    run_search(1'b0, 8'b0000_0001, 8'b1000_0000, e, mg, m);
    n_checks++; if (e != 5) begin n_fail++; $display("FAIL nomatch_latency got=%0d exp=5", e); end
    n_checks++; if (mg !== 5'b00000) begin n_fail++; $display("FAIL nomatch_mag got=%b exp=00000", mg); end
    n_checks++; if (m !== 1'b0) begin n_fail++; $display("FAIL nomatch_match got=%b exp=0", m); end
  endtask

  task automatic test_rotate_pos1();
    int e; logic [4:0] mg; logic m;
    run_search(1'b1, 8'b1000_0001, 8'b0000_0011, e, mg, m);
    n_checks++; if (e != 4) begin n_fail++; $display("FAIL rot1_latency got=%0d exp=4", e); end
    n_checks++; if (mg !== 5'b00010) begin n_fail++; $display("FAIL rot1_mag got=%b exp=00010", mg); end
    n_checks++; if (m !== 1'b1) begin n_fail++; $display("FAIL rot1_match got=%b exp=1", m); end
  endtask

  task automatic test_zero_ref_backpressure();
    int e; logic [4:0] mg; logic m;
    b0.out_ready = 1'b0;
    run_search(1'b0, 8'b0000_0000, 8'b0000_0000, e, mg, m);
    n_checks++; if (e != 1) begin n_fail++; $display("FAIL zero_latency got=%0d exp=1", e); end
    n_checks++; if (mg !== 5'b00100) begin n_fail++; $display("FAIL zero_mag got=%b exp=00100", mg); end
    n_checks++; if (m !== 1'b1) begin n_fail++; $display("FAIL zero_match got=%b exp=1", m); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      n_checks++; if (b0.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", k, b0.out_valid); end
      n_checks++; if (b0.shift_mag !== 5'b00100 || b0.match !== 1'b1) begin n_fail++; $display("FAIL hold_result cyc=%0d got=%b/%b exp=00100/1", k, b0.shift_mag, b0.match); end
      n_checks++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", k, b0.in_ready); end
    end
    b0.out_ready = 1'b1;
    @(posedge clock);
    #1;
    n_checks++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid got=%b exp=0", b0.out_valid); end
    n_checks++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", b0.in_ready); end
  endtask

  task automatic test_busy_ignore();
    int e;
    @(negedge clock);
    b0.ref_ip = 8'b0000_0010; b0.obs_ip = 8'b0000_1000; b0.in_valid = 1'b1;
    @(posedge clock);
    #1;
    // Keep offering a different pair while busy; it must be ignored.
    b0.ref_ip = 8'b0110_0000; b0.obs_ip = 8'b0011_0000;
    n_checks++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready got=%b exp=0", b0.in_ready); end
    e = 99;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (b0.out_valid === 1'b1) begin e = k; break; end
    end
    b0.in_valid = 1'b0;
    n_checks++; if (e != 5) begin n_fail++; $display("FAIL busy_latency got=%0d exp=5", e); end
    n_checks++; if (b0.shift_mag !== 5'b00001) begin n_fail++; $display("FAIL busy_mag got=%b exp=00001", b0.shift_mag); end
  endtask

  task automatic test_reset_mid_search();
    bit seen;
    @(negedge clock);
    for (int k = 0; k < 12; k++) begin
      if (b0.in_ready) break;
      @(negedge clock);
    end
    b0.ref_ip = 8'b0000_0001; b0.obs_ip = 8'b1000_0000; b0.in_valid = 1'b1;
    @(posedge clock);
    #1;
    b0.in_valid = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
      if (b0.out_valid === 1'b1) seen = 1'b1;
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_checks++; if (b0.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=0", b0.in_ready); end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_checks++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready_after got=%b exp=1", b0.in_ready); end
    n_checks++; if (b0.shift_mag !== 5'b00000 || b0.match !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs got=%b/%b exp=00000/0", b0.shift_mag, b0.match); end
    for (int k = 0; k < 6; k++) begin
      if (b0.out_valid === 1'b1) seen = 1'b1;
      @(posedge clock);
      #1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b exp=0", seen); end
  endtask

  initial begin
    b0.in_valid = 1'b0; b0.out_ready = 1'b1; b0.ref_ip = '0; b0.obs_ip = '0;
    b1.in_valid = 1'b0; b1.out_ready = 1'b1; b1.ref_ip = '0; b1.obs_ip = '0;
    test_reset();
    test_delay_pos2();
    test_advance_neg1();
    test_no_match();
    test_rotate_pos1();
    test_zero_ref_backpressure();
    test_busy_ignore();
    test_reset_mid_search();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
